// File: rtl/m2s_adapter.sv
// m2s_adapter: Avalon-MM burst reader that packs 2x256-bit beats into 512-bit Avalon-ST words.
// Optional CSR readback port is compiled in with M2S_CSR_READBACK_EN.
module m2s_adapter #(
    parameter int FIFO_BEATS = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         csr_write,
    input  logic [1:0]   csr_address,
    input  logic [31:0]  csr_writedata,
`ifdef M2S_CSR_READBACK_EN
    input  logic         csr_read,
    output logic [31:0]  csr_readdata,
`endif
    output logic         m_read,
    output logic [32:0]  m_address,
    output logic [1:0]   m_burstcount,
    input  logic         m_waitrequest,
    input  logic [255:0] m_readdata,
    input  logic         m_readdatavalid,
    output logic [511:0] src_data,
    output logic         src_valid,
    input  logic         src_ready,
    output logic         irq
);
    localparam int          PTR_W = $clog2(FIFO_BEATS);
    localparam logic [31:0] CAP   = 32'(FIFO_BEATS);
    localparam logic [PTR_W:0] TWO = (PTR_W+1)'(2);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [31:0]      cmd_left, word_left, pending;
    logic [255:0]     fifo_mem [FIFO_BEATS];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr1;
    logic [PTR_W:0]   fifo_count;

    logic        len_wr, addr_wr, irq_wr, start, accept, push, pop, last_pop, m_read_nxt;
    logic [31:0] pend_eff, cmd_eff;

    assign len_wr   = csr_write && (csr_address == 2'd0);
    assign addr_wr  = csr_write && (csr_address == 2'd1);
    assign irq_wr   = csr_write && (csr_address == 2'd2);
    assign start    = (state == IDLE) && len_wr && (csr_writedata != 32'd0);
    assign accept   = m_read && !m_waitrequest;
    // Beats outside a transfer (e.g. stragglers after a reset) are dropped.
    assign push     = m_readdatavalid && (state == BUSY) && (pending != 32'd0);
    assign pop      = src_valid && src_ready;
    assign last_pop = pop && (word_left == 32'd1);

    assign m_burstcount = 2'd2;
    assign src_valid    = fifo_count >= TWO;
    assign rd_ptr1      = rd_ptr + PTR_W'(1);
    assign src_data     = {fifo_mem[rd_ptr], fifo_mem[rd_ptr1]};

    // Credit check counts this cycle's acceptance but ignores same-cycle returns and pops.
    assign pend_eff = pending + (accept ? 32'd2 : 32'd0);
    assign cmd_eff  = cmd_left - (accept ? 32'd1 : 32'd0);

    always_comb begin
        m_read_nxt = 1'b0;
        if (m_read && m_waitrequest)
            m_read_nxt = 1'b1;
        else if ((state == BUSY) && (cmd_eff != 32'd0) &&
                 (pend_eff + 32'(fifo_count) + 32'd2 <= CAP))
            m_read_nxt = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            m_read     <= 1'b0;
            m_address  <= '0;
            cmd_left   <= '0;
            word_left  <= '0;
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            irq        <= 1'b0;
        end else begin
            m_read <= m_read_nxt;

            if ((state == IDLE) && addr_wr) m_address <= {1'b0, csr_writedata};
            else if (accept)                m_address <= m_address + 33'd64;

            if (start) begin
                cmd_left  <= csr_writedata;
                word_left <= csr_writedata;
            end else begin
                if (accept) cmd_left  <= cmd_left - 32'd1;
                if (pop)    word_left <= word_left - 32'd1;
            end

            pending <= pend_eff - (push ? 32'd1 : 32'd0);

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(2);
            fifo_count <= fifo_count + {{PTR_W{1'b0}}, push} - (pop ? TWO : '0);

            // Completion set takes priority over a coincident clear.
            if (last_pop)    irq <= 1'b1;
            else if (irq_wr) irq <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= m_readdata;
    end

`ifdef M2S_CSR_READBACK_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata <= word_left;
                2'd1:    csr_readdata <= m_address[31:0];
                2'd2:    csr_readdata <= {31'b0, irq};
                default: csr_readdata <= {29'b0, pending == 32'd0, src_valid, state == BUSY};
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_m2s_adapter.sv
// Self-checking bench for m2s_adapter: table of transfers plus hand sequences for
// ignored writes, reset mid-transfer and irq set/clear collision.
module tb_m2s_adapter;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         csr_write = 1'b0;
    logic [1:0]   csr_address = '0;
    logic [31:0]  csr_writedata = '0;
    logic         m_read;
    logic [32:0]  m_address;
    logic [1:0]   m_burstcount;
    logic         m_waitrequest = 1'b0;
    logic [255:0] m_readdata = '0;
    logic         m_readdatavalid = 1'b0;
    logic [511:0] src_data;
    logic         src_valid;
    logic         src_ready = 1'b0;
    logic         irq;

    always #5 clock = ~clock;

    m2s_adapter #(.FIFO_BEATS(8)) dut (
        .clock(clock), .reset(reset),
        .csr_write(csr_write), .csr_address(csr_address), .csr_writedata(csr_writedata),
        .m_read(m_read), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .irq(irq)
    );

    typedef struct { logic [255:0] data; int due; } rbeat_t;
    typedef struct {
        logic [32:0] addr; int len; int stall; int rdly; int exp_stalled; logic [32:0] exp_last;
    } vec_t;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int stall_left = 0, cmd_cnt = 0, word_cnt = 0;
    bit ready_on = 0, stray = 0, prev_wr = 0, last_hs = 0, clr_on_last = 0, clr_fire = 0, done = 0;
    logic [32:0] last_cmd = '0, held_addr = '0;
    rbeat_t      rq[$];
    logic [32:0] exp_addr[$];
    logic [511:0] exp_word[$];

    function automatic logic [255:0] beat(logic [32:0] a, bit k);
        return {8{a[31:0] ^ (k ? 32'hB0B0_0001 : 32'hA0A0_0000)}};
    endfunction

    task automatic chk(string name, logic [511:0] got, logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Slave + sink model; runs at the negedge, drives inputs for the next posedge.
    task automatic bfm();
        bit acc, hs;
        rbeat_t rb;
        logic [32:0] ea;
        m_waitrequest = 1'b0;
        if (prev_wr) chk("hold_read", 512'(m_read), 512'(1));
        if (m_read === 1'b1 && stall_left > 0) begin
            m_waitrequest = 1'b1;
            stall_left--;
            if (prev_wr) chk("hold_addr", 512'(m_address), 512'(held_addr));
            held_addr = m_address;
        end
        prev_wr = m_waitrequest;
        acc = (m_read === 1'b1) && !m_waitrequest;
        if (acc) begin
            cmd_cnt++;
            last_cmd = m_address;
            chk("burstcount", 512'(m_burstcount), 512'(2));
            chk("cmd_expected", 512'(exp_addr.size() != 0), 512'(1));
            if (exp_addr.size() != 0) begin
                ea = exp_addr.pop_front();
                chk("cmd_addr", 512'(m_address), 512'(ea));
            end
            rb.data = beat(m_address, 1'b0); rb.due = cyc + 2; rq.push_back(rb);
            rb.data = beat(m_address, 1'b1); rb.due = cyc + 3; rq.push_back(rb);
        end
        src_ready = ready_on;
        hs = (src_valid === 1'b1) && ready_on;
        if (hs) begin
            word_cnt++;
            chk("word_expected", 512'(exp_word.size() != 0), 512'(1));
            if (exp_word.size() != 0) chk("src_data", src_data, exp_word.pop_front());
            if (exp_word.size() == 0) begin
                last_hs = 1;
                if (clr_on_last) begin
                    csr_write = 1'b1; csr_address = 2'd2; csr_writedata = 32'h0; clr_fire = 1;
                end
            end
        end
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        if (stray) begin
            m_readdatavalid = 1'b1;
            m_readdata      = {8{32'hDEAD_BEEF}};
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            m_readdatavalid = 1'b1;
            m_readdata      = rq[0].data;
            rq.delete(0);
        end
    endtask

    task automatic cycle();
        bfm();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (clr_fire) begin csr_write = 1'b0; clr_fire = 0; end
        if (last_hs) begin
            chk("irq_after_last", 512'(irq), 512'(1));
            chk("idle_m_read", 512'(m_read), 512'(0));
            chk("idle_src_valid", 512'(src_valid), 512'(0));
            last_hs = 0;
            done    = 1;
        end
    endtask

    task automatic csr_wr(logic [1:0] a, logic [31:0] d);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        cycle();
        csr_write = 1'b0;
    endtask

    task automatic start_xfer(logic [32:0] a, int n, bit clr);
        if (clr) begin
            csr_wr(2'd2, 32'h0);
            chk("irq_clear", 512'(irq), 512'(0));
        end
        csr_wr(2'd1, a[31:0]);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a + 33'(64 * i));
            exp_word.push_back({beat(a + 33'(64 * i), 1'b0), beat(a + 33'(64 * i), 1'b1)});
        end
        cmd_cnt = 0; word_cnt = 0; done = 0;
        csr_wr(2'd0, 32'(n));
        chk("lat_read0", 512'(m_read), 512'(0));
        cycle();
        chk("lat_read1", 512'(m_read), 512'(1));
    endtask

    task automatic run_done(int limit);
        int t = 0;
        while (!done && t < limit) begin cycle(); t++; end
        chk("xfer_done", 512'(done), 512'(1));
    endtask

    initial begin
        vec_t tv[5];
        int t;
        tv[0] = '{33'h0_0000_1000, 3, 0, 0,  0, 33'h0_0000_1080};
        tv[1] = '{33'h0_0000_2000, 4, 0, 30, 4, 33'h0_0000_20C0};
        tv[2] = '{33'h0_0000_1000, 2, 5, 0,  0, 33'h0_0000_1040};
        tv[3] = '{33'h0_0000_3000, 6, 0, 30, 4, 33'h0_0000_3140};
        tv[4] = '{33'h0_FFFF_FFC0, 2, 0, 0,  0, 33'h1_0000_0000};

        repeat (3) cycle();
        reset = 1'b1;
        chk("rst_m_read", 512'(m_read), 512'(0));
        chk("rst_src_valid", 512'(src_valid), 512'(0));
        chk("rst_irq", 512'(irq), 512'(0));
        chk("rst_m_address", 512'(m_address), 512'(0));

        for (int v = 0; v < 5; v++) begin
            stall_left = tv[v].stall;
            ready_on   = (tv[v].rdly == 0);
            start_xfer(tv[v].addr, tv[v].len, 1);
            if (tv[v].rdly > 0) begin
                repeat (tv[v].rdly) cycle();
                chk("cmds_while_blocked", 512'(cmd_cnt), 512'(tv[v].exp_stalled));
                chk("m_read_throttled", 512'(m_read), 512'(0));
                chk("src_valid_held", 512'(src_valid), 512'(1));
                ready_on = 1;
            end
            run_done(500);
            chk("cmd_count", 512'(cmd_cnt), 512'(tv[v].len));
            chk("word_count", 512'(word_cnt), 512'(tv[v].len));
            chk("last_addr", 512'(last_cmd), 512'(tv[v].exp_last));
            chk("stall_used", 512'(stall_left), 512'(0));
        end

        // LEN/ADDR writes while busy and a zero LEN write while idle are ignored.
        ready_on = 1;
        start_xfer(33'h0_0000_5000, 3, 1);
        csr_wr(2'd0, 32'd9);
        csr_wr(2'd1, 32'h8000);
        run_done(500);
        chk("busy_wr_cmds", 512'(cmd_cnt), 512'(3));
        chk("busy_wr_last", 512'(last_cmd), 512'(33'h0_0000_5080));
        csr_wr(2'd0, 32'd0);
        repeat (4) cycle();
        chk("len0_m_read", 512'(m_read), 512'(0));
        chk("len0_cmds", 512'(cmd_cnt), 512'(3));
        chk("len0_irq", 512'(irq), 512'(1));

        // Reset mid-transfer with irq pending, then stray beats in IDLE.
        ready_on = 0;
        start_xfer(33'h0_0000_7000, 4, 0);
        t = 0;
        while (cmd_cnt < 2 && t < 50) begin cycle(); t++; end
        chk("mid_cmds", 512'(cmd_cnt >= 2), 512'(1));
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("mid_rst_m_read", 512'(m_read), 512'(0));
        chk("mid_rst_src_valid", 512'(src_valid), 512'(0));
        chk("mid_rst_irq", 512'(irq), 512'(0));
        rq.delete(); exp_addr.delete(); exp_word.delete();
        stray = 1;
        repeat (3) cycle();
        stray = 0;
        cycle();
        chk("stray_src_valid", 512'(src_valid), 512'(0));
        chk("stray_m_read", 512'(m_read), 512'(0));
        ready_on = 1;
        start_xfer(33'h0_0000_9000, 1, 0);
        run_done(200);
        chk("post_rst_words", 512'(word_cnt), 512'(1));

        // IRQ clear coincident with completion: set wins; a later clear works.
        clr_on_last = 1;
        start_xfer(33'h0_0000_A000, 1, 0);
        run_done(200);
        clr_on_last = 0;
        csr_wr(2'd2, 32'h1);
        chk("irq_cleared", 512'(irq), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/m2s_adapter.md
Name: m2s_adapter

Overview:
- Upstream neighbour of the stream-to-memory writer.
- Fetches a CSR-programmed number of 512-bit words from memory over an Avalon-MM read master, using bursts of 2×256-bit beats.
- Packs each beat pair into one 512-bit word on an Avalon-ST source that feeds the ChaCha datapath.
- Raises irq when the last word has been accepted downstream.

Parameters:
- FIFO_BEATS, 8, depth of the internal read-return buffer in 256-bit beats. Power of 2, minimum 4.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous reset, active-low: reset==0 at a posedge resets the block.
- csr_write  in  1  CSR write strobe.
- csr_address  in  2  0=LEN, 1=ADDR, 2=IRQ, 3=reserved (writes ignored).
- csr_writedata  in  32  CSR write data.
- m_read  out  1  read command valid.
- m_address  out  33  byte address of the current burst.
- m_burstcount  out  2  constant 2.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  256  returned beat.
- m_readdatavalid  in  1  returned beat valid.
- src_data  out  512  packed word.
- src_valid  out  1  word valid.
- src_ready  in  1  downstream ready.
- irq  out  1  completion interrupt, level, sticky until cleared.

Behaviour:
- Reset values: m_read=0, m_address=0, src_valid=0, irq=0. All counters 0, FIFO empty, state IDLE. src_data is don't-care.
- States:
  - IDLE -> BUSY on a CSR write to LEN with nonzero data.
  - BUSY -> IDLE in the cycle after the final src handshake.
- Counters (32-bit, non-wrapping):
  - cmd_left: bursts still to issue.
  - word_left: words still to deliver.
  - pending: beats requested but not yet returned (0..FIFO_BEATS).
- LEN write in IDLE: cmd_left=word_left=data. Data 0 is ignored (stays IDLE, no irq).
- ADDR write in IDLE: m_address={1'b0,data}. Bits [5:0] are the caller's responsibility; no alignment fix-up.
- LEN/ADDR writes in BUSY are ignored.
- IRQ write (any data) clears irq in any state. If irq set and clear coincide, set wins.
- Read issue:
  - m_read may rise only in BUSY with cmd_left!=0 and pending + fifo_count + 2 <= FIFO_BEATS, so returned data can never overflow.
  - Once m_read is high, m_address and m_read are held stable until a cycle with m_waitrequest==0.
  - On acceptance: cmd_left-1, m_address+64, pending+2.
  - m_read deasserts in the following cycle if cmd_left is now 0 or credits are insufficient.
  - Back-to-back commands are allowed.
- Return path: each m_readdatavalid beat pushes into the FIFO (pending-1). A push and a pop in the same cycle are legal.
- Output:
  - src_valid=1 whenever the FIFO holds >=2 beats.
  - src_data[511:256] = older beat, [255:0] = newer beat. This matches the downstream writer's split order.
  - Data is registered out of the FIFO; there is no combinational path from m_readdata to src_data.
  - Handshake on src_valid&src_ready pops 2 beats and decrements word_left.
  - src_valid/src_data stay stable while src_ready=0.
- Completion: the handshake with word_left==1 sets irq on the next edge; state returns to IDLE.
- Simultaneous events:
  - Command acceptance and beat return in one cycle: pending changes by +1 net.
  - Credit check uses registered values, so it is conservative by at most one cycle.
- Reset mid-operation:
  - Drops m_read immediately (registered) and empties the FIFO.
  - Beats arriving after reset in IDLE are discarded; FIFO and counters are unaffected.
- Latency: LEN write -> m_read high on the second edge. Second beat of a burst returned -> src_valid high on the next edge.

Optional Feature:
- Macro M2S_CSR_READBACK_EN.
- Defined: adds ports csr_read (in, 1) and csr_readdata (out, 32), with one-cycle read latency.
  - Addr 0 returns word_left.
  - Addr 1 returns m_address[31:0].
  - Addr 2 returns {31'b0, irq}.
  - Addr 3 returns {29'b0, pending==0, src_valid, state==BUSY}.
  - csr_readdata resets to 0.
- Undefined: ports absent; CSRs are write-only. All other behaviour is identical.

Test Plan:
- ADDR=0x1000, LEN=3, slave zero-wait, returns beats A0..A5 two cycles after each command -> commands at 0x1000/0x1040/0x1080 with burstcount 2; src words {A0,A1},{A2,A3},{A4,A5}; irq=1 one edge after third handshake; state IDLE.
- LEN=4, src_ready=0 throughout, FIFO_BEATS=8 -> exactly 4 bursts issued, then m_read stays 0. After src_ready=1: 4 words, irq.
- m_waitrequest=1 for 5 cycles on first command -> m_read and m_address=0x1000 held constant all 5 cycles; single acceptance only.
- LEN write of 0 and LEN/ADDR writes during BUSY (LEN=9, ADDR=0x8000) -> no state change; original transfer completes with original addresses.
- irq pending, IRQ write coincident with final handshake of a new LEN=1 transfer -> irq remains 1. A later IRQ write clears it.
- reset=0 for one edge mid-transfer after 2 of 4 bursts, then stray m_readdatavalid beats -> m_read=0, src_valid=0, irq=0, beats ignored. New LEN=1 transfer completes normally.
